// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: state_t (LOOKUP/REFILL), off_w/idx_w/tag_w address-split widths.
package icache_pkg;

   typedef enum logic {
      LOOKUP = 1'b0,
      REFILL = 1'b1
   } state_t;

   // Word-offset bits inside a line.
   function automatic int off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   // Line-index bits.
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Whatever is left of the 32-bit word address becomes the tag.
   function automatic int tag_w(input int lines, input int words_per_line);
      return 32 - $clog2(lines) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/icache_if.sv
// CPU fetch port plus backing-memory read port of the instruction cache.
// Latency: n/a (wires only).
// Backpressure: cpu_ready stalls the CPU; mem_ack paces the refill.
//
// Modports: slave = the cache itself, master = CPU/memory environment.
interface icache_if;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  cpu_req, cpu_addr, flush, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, mem_req, mem_addr
   );

   modport master (
      output cpu_req, cpu_addr, flush, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, mem_req, mem_addr
   );
endinterface

// File: rtl/icache_data_array.sv
// Instruction data storage, one 32-bit word per entry, addressed {index, offset}.
// Latency: combinational read, write lands on the next rising edge.
// Backpressure: none; writes are accepted every cycle we is high.
//
// Ports: clk, we/waddr/wdata (single-word write), raddr/rdata (async read).
module icache_data_array #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   localparam int DEPTH = 1 << AW;

   // Contents are qualified by the valid bits in the controller, so no reset.
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with line refill over a word-wide memory port.
// Latency: hit returns same cycle; miss returns WORDS_PER_LINE acks plus one lookup cycle.
// Backpressure: cpu_ready low stalls the CPU; mem_addr holds until mem_ack.
//
// Ports: clk, rst_n, bus (icache_if.slave); with ICACHE_STATS_EN defined also
// hit_count/miss_count.
import icache_pkg::*;

module icache_ctrl #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   icache_if.slave     bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int OFF_W = off_w(WORDS_PER_LINE);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(LINES, WORDS_PER_LINE);

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;

   assign off = bus.cpu_addr[OFF_W-1:0];
   assign idx = bus.cpu_addr[OFF_W +: IDX_W];
   assign tag = bus.cpu_addr[31 -: TAG_W];

   state_t           state;
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [TAG_W-1:0] lat_tag;
   logic [IDX_W-1:0] lat_idx;
   logic [OFF_W-1:0] cnt;
   logic             flush_pend;
   logic             mem_req_q;

   logic             hit;
   logic             miss;
   logic             fill_we;
   logic             last_ack;
   logic [31:0]      rd_dat;

   // A flush in the lookup cycle forces a miss so stale data is never returned.
   assign hit      = (state == LOOKUP) & bus.cpu_req & valid[idx]
                     & (tags[idx] == tag) & ~bus.flush;
   assign miss     = (state == LOOKUP) & bus.cpu_req & ~hit;
   assign fill_we  = (state == REFILL) & bus.mem_ack;
   assign last_ack = fill_we & (cnt == {OFF_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOOKUP;
         valid      <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         mem_req_q  <= 1'b0;
         lat_tag    <= '0;
         lat_idx    <= '0;
      end else begin
         case (state)
            LOOKUP: begin
               if (bus.flush) valid <= '0;
               if (miss) begin
                  state     <= REFILL;
                  mem_req_q <= 1'b1;
                  lat_tag   <= tag;
                  lat_idx   <= idx;
                  cnt       <= '0;
               end
            end
            REFILL: begin
               if (bus.flush) flush_pend <= 1'b1;
               if (bus.mem_ack) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == {OFF_W{1'b1}}) begin
                     state      <= LOOKUP;
                     mem_req_q  <= 1'b0;
                     flush_pend <= 1'b0;
                     // A flush seen during the refill also kills the new line.
                     if (flush_pend | bus.flush) valid <= '0;
                     else                        valid[lat_idx] <= 1'b1;
                  end
               end
            end
            default: state <= LOOKUP;
         endcase
      end
   end

   // Tags are qualified by valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (last_ack) tags[lat_idx] <= lat_tag;
   end

   icache_data_array #(
      .AW (OFF_W + IDX_W)
   ) u_data (
      .clk   (clk),
      .we    (fill_we),
      .waddr ({lat_idx, cnt}),
      .wdata (bus.mem_rdata),
      .raddr ({idx, off}),
      .rdata (rd_dat)
   );

   assign bus.cpu_ready = hit;
   assign bus.cpu_rdata = rd_dat;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = {lat_tag, lat_idx, cnt};

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit)  hit_count  <= hit_count + 32'd1;
         if (miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: hit/miss timing, refill addressing, waits, flush, reset.
// Latency: n/a.
// Backpressure: mem_ack driven by the stimulus; memory returns 0xA0 + mem_addr.
module tb_icache_ctrl;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   icache_if bus ();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache_ctrl #(
      .LINES          (16),
      .WORDS_PER_LINE (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory: each word's content is its address plus 0xA0.
   assign bus.mem_rdata = 32'h0000_00A0 + bus.mem_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Four tied-ack refill cycles starting at base, then the lookup cycle after.
   task automatic refill_tied(input logic [31:0] base, input logic [31:0] exp_rdata,
                              input int flush_at, input bit exp_hit);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_ack = 1'b1;
         bus.flush   = (i == flush_at);
         #1;
         chk("refill_req", {31'b0, bus.mem_req}, 32'd1);
         chk("refill_addr", bus.mem_addr, base + i);
         chk("refill_ready", {31'b0, bus.cpu_ready}, 32'd0);
      end
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("post_refill_memreq", {31'b0, bus.mem_req}, 32'd0);
      if (exp_hit) begin
         chk("post_refill_ready", {31'b0, bus.cpu_ready}, 32'd1);
         chk("post_refill_rdata", bus.cpu_rdata, exp_rdata);
      end else begin
         chk("post_refill_miss", {31'b0, bus.cpu_ready}, 32'd0);
      end
   endtask

   initial begin
      rst_n        = 1'b1;
      bus.cpu_req  = 1'b0;
      bus.cpu_addr = 32'h0;
      bus.flush    = 1'b0;
      bus.mem_ack  = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_memreq", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_ready", {31'b0, bus.cpu_ready}, 32'd0);
      chk("rst_memaddr", bus.mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold miss at 0x10 with memory acking every cycle.
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h10;
      bus.mem_ack  = 1'b1;
      #1;
      chk("cold_miss_ready", {31'b0, bus.cpu_ready}, 32'd0);
      chk("cold_miss_memreq", {31'b0, bus.mem_req}, 32'd0);
      refill_tied(32'h10, 32'hB0, -1, 1'b1);

      // Hits inside the line just filled.
      @(negedge clk);
      bus.cpu_addr = 32'h12;
      #1;
      chk("hit12_ready", {31'b0, bus.cpu_ready}, 32'd1);
      chk("hit12_rdata", bus.cpu_rdata, 32'hB2);
      chk("hit12_memreq", {31'b0, bus.mem_req}, 32'd0);
      @(negedge clk);
      bus.cpu_addr = 32'h13;
      #1;
      chk("hit13_rdata", bus.cpu_rdata, 32'hB3);

      // Same index, different tag: replaces the line, then 0x10 misses again.
      @(negedge clk);
      bus.cpu_addr = 32'h50;
      #1;
      chk("conflict50_ready", {31'b0, bus.cpu_ready}, 32'd0);
      refill_tied(32'h50, 32'hF0, -1, 1'b1);
      @(negedge clk);
      bus.cpu_addr = 32'h10;
      #1;
      chk("evicted10_ready", {31'b0, bus.cpu_ready}, 32'd0);
      refill_tied(32'h10, 32'hB0, -1, 1'b1);

      // No request, no refill.
      @(negedge clk);
      bus.cpu_req  = 1'b0;
      bus.cpu_addr = 32'h70;
      #1;
      chk("idle_ready", {31'b0, bus.cpu_ready}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("idle_memreq", {31'b0, bus.mem_req}, 32'd0);
      end

      // Three wait cycles per word; cpu_addr moves mid-refill.
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h30;
      #1;
      chk("wait_miss_ready", {31'b0, bus.cpu_ready}, 32'd0);
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (w == 0 && k == 1) bus.cpu_addr = 32'h33;
            #1;
            chk("wait_memreq", {31'b0, bus.mem_req}, 32'd1);
            chk("wait_addr_stable", bus.mem_addr, 32'h30 + w);
            chk("wait_ready", {31'b0, bus.cpu_ready}, 32'd0);
         end
         @(negedge clk);
         bus.mem_ack = 1'b1;
         #1;
         chk("ack_addr", bus.mem_addr, 32'h30 + w);
         chk("ack_ready", {31'b0, bus.cpu_ready}, 32'd0);
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      chk("wait_done_ready", {31'b0, bus.cpu_ready}, 32'd1);
      chk("wait_done_rdata", bus.cpu_rdata, 32'hD3);
      chk("wait_done_memreq", {31'b0, bus.mem_req}, 32'd0);

      // Flush in LOOKUP reports a miss that very cycle and clears every line.
      @(negedge clk);
      bus.flush   = 1'b1;
      bus.mem_ack = 1'b1;
      #1;
      chk("flush_lookup_ready", {31'b0, bus.cpu_ready}, 32'd0);
      refill_tied(32'h30, 32'hD3, -1, 1'b1);
      @(negedge clk);
      bus.cpu_addr = 32'h10;
      #1;
      chk("flushed10_ready", {31'b0, bus.cpu_ready}, 32'd0);
      refill_tied(32'h10, 32'hB0, -1, 1'b1);

      // Flush pulse during refill of 0x20 (fresh reset so the stats start at 0).
      @(negedge clk);
      rst_n       = 1'b0;
      bus.cpu_req = 1'b0;
      #1;
      chk("rst2_memreq", {31'b0, bus.mem_req}, 32'd0);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h20;
      #1;
      chk("flush20_miss", {31'b0, bus.cpu_ready}, 32'd0);
      refill_tied(32'h20, 32'hC0, 1, 1'b0);
      refill_tied(32'h20, 32'hC0, -1, 1'b1);
`ifdef ICACHE_STATS_EN
      chk("stats_miss_count", miss_count, 32'd2);
      chk("stats_hit_before", hit_count, 32'd0);
`endif
      @(negedge clk);
      bus.cpu_req = 1'b0;
      #1;
`ifdef ICACHE_STATS_EN
      chk("stats_hit_after", hit_count, 32'd1);
      chk("stats_miss_after", miss_count, 32'd2);
`endif

      // Reset after the second ack of a refill.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n        = 1'b1;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h10;
      bus.mem_ack  = 1'b1;
      #1;
      chk("r30_miss", {31'b0, bus.cpu_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("r30_addr", bus.mem_addr, 32'h10 + i);
      end
      rst_n = 1'b0;
      #1;
      chk("r30_async_memreq", {31'b0, bus.mem_req}, 32'd0);
      chk("r30_async_memaddr", bus.mem_addr, 32'h0);
      chk("r30_async_ready", {31'b0, bus.cpu_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("r30_after_miss", {31'b0, bus.cpu_ready}, 32'd0);
      refill_tied(32'h10, 32'hB0, -1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, meaning 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have ports, one per line:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  fetch request.
- cpu_addr  input  32  word address; word index, not byte address.
- cpu_rdata  output  32  fetched instruction.
- cpu_ready  output  1  cpu_rdata valid this cycle.
- flush  input  1  invalidate all lines.
- mem_req  output  1  backing-memory word read request.
- mem_addr  output  32  backing-memory word address.
- mem_rdata  input  32  backing-memory read data.
- mem_ack  input  1  mem_rdata valid; completes current mem_req.

Function
REQ-004 SHALL split cpu_addr as offset = low log2(WORDS_PER_LINE) bits, index = next log2(LINES) bits, tag = remaining upper bits.
REQ-005 SHALL implement FSM states LOOKUP and REFILL; reset state LOOKUP.
REQ-006 In LOOKUP, hit = cpu_req & valid[index] & tag match; cpu_ready and cpu_rdata SHALL be combinational, same cycle, zero latency.
REQ-007 In LOOKUP with cpu_req and miss, cpu_ready SHALL be 0 and next state SHALL be REFILL, latching tag and index of cpu_addr.
REQ-008 In REFILL, mem_req SHALL be 1 and mem_addr = {latched tag, latched index, word counter}; counter starts at 0.
REQ-009 mem_addr SHALL stay stable while mem_req=1 and no mem_ack; each mem_ack SHALL write mem_rdata into the line at the counter and advance the counter.
REQ-010 On the mem_ack for word WORDS_PER_LINE-1, the FSM SHALL set valid and tag for the line, drop mem_req the next cycle, and return to LOOKUP.
REQ-011 Miss latency SHALL be N acks plus one LOOKUP cycle: with mem_ack tied high, cpu_ready rises exactly WORDS_PER_LINE+1 cycles after the missing request.
REQ-012 cpu_ready SHALL be 0 in REFILL; cpu_addr changes during REFILL SHALL NOT alter the refill, and LOOKUP re-evaluates the current cpu_addr.
REQ-013 cpu_req=0 SHALL never start a refill; cpu_rdata is don't-care when cpu_ready=0.
REQ-014 flush in LOOKUP SHALL clear all valid bits at the next edge, and that same cycle SHALL report a miss.
REQ-015 flush in REFILL SHALL be latched and applied on return to LOOKUP, invalidating the just-refilled line too.
REQ-016 A refill SHALL overwrite the existing line at that index regardless of previous tag (direct-mapped replacement).

Reset
REQ-017 On rst_n low: all valid bits=0, state LOOKUP, word counter=0, pending flush=0, mem_req=0, cpu_ready=0, mem_addr=0.
REQ-018 Reset asserted mid-REFILL SHALL drop mem_req immediately (asynchronously) and abandon the line, leaving it invalid.
REQ-019 Tag and data arrays SHALL need no reset.

Configuration
REQ-020 Macro ICACHE_STATS_EN SHALL, when defined, add outputs hit_count[31:0] and miss_count[31:0], reset to 0 and wrapping at 2^32.
REQ-021 With ICACHE_STATS_EN defined, hit_count SHALL increment each cycle cpu_req&cpu_ready, including the post-refill hit, and miss_count SHALL increment on each LOOKUP->REFILL transition.
REQ-022 Without ICACHE_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-023 Package icache_pkg SHALL hold the FSM state enum and the offset/index/tag width localparam functions.
REQ-024 One sub-module, icache_data_array, SHALL hold data words with a combinational read and a synchronous single-word write; tags and valid bits stay in icache_ctrl.

Verification
REQ-025 Reset, cpu_req=1, cpu_addr=0x10, mem_ack tied 1, mem_rdata=0xA0+mem_addr -> mem_addr 0x10..0x13 in 4 cycles; cpu_ready=1 on cycle 5 with rdata 0xB0.
REQ-026 After REQ-025, cpu_addr=0x12 -> cpu_ready=1 same cycle, rdata 0xB2, no mem_req.
REQ-027 cpu_addr=0x50, which has the same index and a different tag -> refill of 0x50..0x53; afterwards 0x10 misses again.
REQ-028 mem_ack with 3 random wait cycles per word -> mem_addr stable while waiting, correct data, cpu_ready only after the 4th ack.
REQ-029 flush pulse during REFILL of 0x20 -> refill completes, then 0x20 misses again; with ICACHE_STATS_EN, miss_count=2.
REQ-030 rst_n low after the 2nd ack of a refill -> mem_req=0 at once; after release, 0x10 misses.
